// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event path: FSM state encoding, event kinds and
// the hold/repeat counter width helper.
package btn_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_LONG  = 2'd2
    } state_e;

    // Exactly one event kind per cycle, which keeps the output pulses mutually exclusive.
    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_PRESS   = 3'd1,
        EV_RELEASE = 3'd2,
        EV_LONG    = 3'd3,
        EV_REPEAT  = 3'd4
    } event_e;

    function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
        return $clog2((long_cycles > repeat_cycles) ? long_cycles : repeat_cycles) + 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered previous-value edge detector for synchronous single-bit inputs.
// The previous value resets to 1 so a level already high through reset is not a rise.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= din;
        end
    end

    assign rise = din & ~r_prev;
    assign fall = ~din & r_prev;

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into one-cycle press/release/long/repeat events,
// plus a held level and a wrapping press counter. All outputs are registered.
module button_event
    import btn_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 25_000_000,
    parameter int REPEAT_CYCLES     = 5_000_000,
    parameter bit REPEAT_EN         = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       release_long,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam int CNT_W = cnt_width(LONG_PRESS_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             w_rise;
    logic             w_fall;
    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    event_e           w_event;

    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_release_long;
    logic             r_long_pulse;
    logic             r_repeat_pulse;
    logic             r_held;
    logic [7:0]       r_press_count;

    edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .din   (btn_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // PRESS and LONG are only reachable while the sampled level was 1, so a fall there
    // is the same as btn_level = 0. Release is tested first so it wins over thresholds.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_event      = EV_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_PRESS;
                    w_cnt_next   = '0;
                    w_event      = EV_PRESS;
                end
            end
            ST_PRESS: begin
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_event      = EV_RELEASE;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_next = ST_LONG;
                    w_cnt_next   = '0;
                    w_event      = EV_LONG;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                    w_event      = EV_RELEASE;
                end else if (!REPEAT_EN) begin
                    w_cnt_next   = '0;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_next   = '0;
                    w_event      = EV_REPEAT;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_release_long  <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_repeat_pulse  <= 1'b0;
            r_held          <= 1'b0;
            r_press_count   <= 8'd0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_press_pulse   <= (w_event == EV_PRESS);
            r_release_pulse <= (w_event == EV_RELEASE);
            r_release_long  <= (w_event == EV_RELEASE) && (r_state == ST_LONG);
            r_long_pulse    <= (w_event == EV_LONG);
            r_repeat_pulse  <= (w_event == EV_REPEAT);
            r_held          <= (w_state_next != ST_IDLE);
            if (w_event == EV_PRESS) begin
                r_press_count <= r_press_count + 8'd1;
            end
        end
    end

    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign release_long  = r_release_long;
    assign long_pulse    = r_long_pulse;
    assign repeat_pulse  = r_repeat_pulse;
    assign held          = r_held;
    assign press_count   = r_press_count;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: one repeat-enabled and one repeat-disabled
// instance share the stimulus and are compared every cycle against a hold-length model.
module tb_button_event;

    localparam int LP = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_level;

    logic       a_press, a_rel, a_rel_long, a_long, a_rep, a_held;
    logic [7:0] a_count;
    logic       b_press, b_rel, b_rel_long, b_long, b_rep, b_held;
    logic [7:0] b_count;

    logic [13:0] obs_a;
    logic [13:0] obs_b;

    int errors = 0;
    int checks = 0;
    int press_seen;
    int release_seen;

    typedef struct {
        bit          pressed;
        int          hold;
        int          count;
        bit          prev;
        logic [13:0] expv;
    } mdl_t;

    mdl_t m_rep;
    mdl_t m_norep;

    always #5 clk = ~clk;

    button_event #(.LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP), .REPEAT_EN(1'b1)) u_dut_rep (
        .clk(clk), .reset(reset), .btn_level(btn_level),
        .press_pulse(a_press), .release_pulse(a_rel), .release_long(a_rel_long),
        .long_pulse(a_long), .repeat_pulse(a_rep), .held(a_held), .press_count(a_count)
    );

    button_event #(.LONG_PRESS_CYCLES(LP), .REPEAT_CYCLES(RP), .REPEAT_EN(1'b0)) u_dut_norep (
        .clk(clk), .reset(reset), .btn_level(btn_level),
        .press_pulse(b_press), .release_pulse(b_rel), .release_long(b_rel_long),
        .long_pulse(b_long), .repeat_pulse(b_rep), .held(b_held), .press_count(b_count)
    );

    assign obs_a = {a_press, a_rel, a_rel_long, a_long, a_rep, a_held, a_count};
    assign obs_b = {b_press, b_rel, b_rel_long, b_long, b_rep, b_held, b_count};

    // Model: hold = edges since the accepted press; events follow from hold vs LP/RP.
    function automatic mdl_t mdl_step(input mdl_t m, input bit b, input bit rep_en);
        mdl_t n = m;
        bit p = 0, r = 0, rl = 0, lg = 0, rp = 0;
        if (!n.pressed) begin
            if (b && !n.prev) begin
                p         = 1;
                n.pressed = 1;
                n.hold    = 0;
                n.count   = (n.count + 1) % 256;
            end
        end else begin
            n.hold = n.hold + 1;
            if (!b) begin
                r         = 1;
                rl        = (n.hold > LP);
                n.pressed = 0;
            end else begin
                lg = (n.hold == LP);
                rp = rep_en && (n.hold > LP) && (((n.hold - LP) % RP) == 0);
            end
        end
        n.prev = b;
        n.expv = {p, r, rl, lg, rp, n.pressed, 8'(n.count)};
        return n;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.pressed = 0;
        n.hold    = 0;
        n.count   = 0;
        n.prev    = 1;
        n.expv    = '0;
        return n;
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic b, input string tag);
        btn_level = b;
        @(posedge clk);
        m_rep   = mdl_step(m_rep, b, 1'b1);
        m_norep = mdl_step(m_norep, b, 1'b0);
        @(negedge clk);
        if (a_press) press_seen++;
        if (a_rel) release_seen++;
        check({tag, "/rep"}, obs_a, m_rep.expv);
        check({tag, "/norep"}, obs_b, m_norep.expv);
    endtask

    task automatic hold_steps(input logic b, input int n, input string tag);
        for (int i = 0; i < n; i++) step(b, tag);
    endtask

    task automatic apply_reset(input int cycles, input string tag);
        reset = 1'b0;
        #1;
        m_rep   = mdl_reset();
        m_norep = mdl_reset();
        check({tag, "/rep"}, obs_a, 14'h0);
        check({tag, "/norep"}, obs_b, 14'h0);
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        btn_level = 1'b1;
        m_rep   = mdl_reset();
        m_norep = mdl_reset();
        #1;
        apply_reset(2, "reset_state");

        // Button held through reset must not register a press.
        hold_steps(1'b1, 3, "held_thru_reset");
        hold_steps(1'b0, 2, "idle_low");

        // Short press.
        hold_steps(1'b1, 3, "short_hold");
        hold_steps(1'b0, 2, "short_release");

        // Long hold: edges k..k+20 high, then release.
        hold_steps(1'b1, 21, "long_hold");
        hold_steps(1'b0, 2, "long_release");

        // Release on edge k+8 beats the long threshold.
        hold_steps(1'b1, LP, "boundary_hold");
        hold_steps(1'b0, 2, "boundary_release");

        // Reset at edge k+10, button kept high afterwards.
        hold_steps(1'b1, 11, "midhold");
        apply_reset(2, "midhold_reset");
        hold_steps(1'b1, 5, "post_reset_held");
        hold_steps(1'b0, 1, "post_reset_low");
        hold_steps(1'b1, 2, "post_reset_press");
        hold_steps(1'b0, 1, "post_reset_release");

        // 30-cycle hold: one long pulse, repeats only on the enabled instance.
        hold_steps(1'b1, 31, "hold30");
        hold_steps(1'b0, 2, "hold30_release");

        // Wrap: 256 presses from a cleared counter.
        apply_reset(1, "wrap_reset");
        hold_steps(1'b0, 1, "wrap_pre");
        press_seen   = 0;
        release_seen = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b1, "wrap_press");
            step(1'b0, "wrap_release");
        end
        check("wrap_press_pulses", 14'(press_seen), 14'd256);
        check("wrap_release_pulses", 14'(release_seen), 14'd256);
        check("wrap_count", {6'd0, a_count}, 14'd0);

        // Randomized holds, gaps and occasional mid-hold resets.
        for (int i = 0; i < 40; i++) begin
            int hold_len;
            int gap_len;
            hold_len = int'($urandom_range(1, 30));
            gap_len  = int'($urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                hold_steps(1'b1, int'($urandom_range(1, 20)), "rand_prehold");
                apply_reset(int'($urandom_range(1, 3)), "rand_reset");
            end
            hold_steps(1'b1, hold_len, "rand_hold");
            hold_steps(1'b0, gap_len, "rand_gap");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
